operand_input: RTL and testbench
================================

OPERAND_INPUT -- requirements
Module: operand_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a press or a release; legal range 1..65535.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the btn synchronizer; legal range 2..4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sw  input  16  operand value from user switches, asynchronous to clk, sampled only at capture.
REQ-006 btn  input  1  user "enter" push-button, asynchronous, bouncy, active-high.
REQ-007 in  output  16  captured operand, fed directly to the processor state machine's in port.
REQ-008 rq  output  1  one-cycle request pulse announcing a new operand on in.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 count  output  8  number of operands issued since reset, modulo 256.

Function
REQ-011 btn SHALL pass through a SYNC_STAGES-deep synchronizer; the FSM SHALL observe only the synchronized signal btn_s.
REQ-012 FSM states SHALL be IDLE, PRESS, ISSUE, RELEASE.
REQ-013 IDLE: when btn_s=1, go to PRESS and clear the debounce counter.
REQ-014 PRESS: counter increments each cycle btn_s=1; if btn_s=0, return to IDLE; when counter = DEBOUNCE_CYCLES-1 with btn_s=1, go to ISSUE.
REQ-015 ISSUE: lasts exactly one cycle; in <= sw on entry, so the value is valid in the same cycle rq=1; count increments; next state RELEASE.
REQ-016 rq SHALL be 1 only while in ISSUE, giving exactly one pulse per accepted press however long btn is held.
REQ-017 RELEASE: counter cleared whenever btn_s=1 and incremented while btn_s=0; go to IDLE when counter = DEBOUNCE_CYCLES-1 with btn_s=0.
REQ-018 in SHALL hold its value from ISSUE until the next ISSUE; changes on sw outside ISSUE SHALL have no effect.
REQ-019 Latency: with btn held stable high, rq SHALL assert on the rising edge SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge that samples btn=1.
REQ-020 A bounce (btn_s low for any cycle) during PRESS SHALL produce no rq and no change to in or count.
REQ-021 A bounce during RELEASE SHALL restart the release debounce and SHALL NOT produce a second rq.
REQ-022 count SHALL wrap from 255 to 0 without any other effect.
REQ-023 The debounce counter SHALL be 16 bits wide and SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, in=16'd0, rq=0, busy=0, count=0, debounce counter=0, and all synchronizer flops=0.
REQ-025 Reset asserted in any state, including ISSUE, SHALL take priority over every transition; rq SHALL be 0 in the cycle after that edge.
REQ-026 After reset release, a btn already held high SHALL be treated as a new press and follow REQ-019 timing.

Structure
REQ-027 State encodings and the DEBOUNCE_CYCLES/SYNC_STAGES defaults SHALL live in a shared processor package; the operand width (16) SHALL be taken from the same package constant used by the ALU.
REQ-028 The synchronizer SHALL be a separate sub-module named sync_bit (parameter STAGES), reusable for other asynchronous inputs.
REQ-029 All outputs SHALL be registered; no combinational path from sw or btn to any output.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10-unit clock)
REQ-030 sw=34, btn high 20 cycles then low -> exactly one rq pulse on edge 7 after the first btn sample, in=34, count=1, busy returns to 0 four stable-low cycles after btn_s falls.
REQ-031 btn pulses high 2 cycles, low 1, high 2, low -> no rq, in=0, count=0, state back in IDLE.
REQ-032 Second press with sw=10 after the first completes -> second rq, in=10; sw toggled to 99 between presses leaves in at 34 until that rq.
REQ-033 Bounce during RELEASE (btn low 2, high 1, low 6) -> no extra rq; IDLE reached 4 cycles after the final fall of btn_s.
REQ-034 rst asserted in the ISSUE cycle -> next cycle rq=0, in=0, count=0, state=IDLE; holding btn through reset release yields one rq per REQ-026.
REQ-035 256 complete presses -> count wraps to 0; rq and in behave normally on press 257.

Source files
------------

// File: rtl/operand_input_pkg.sv
// Shared processor definitions: datapath width, operand-entry FSM encoding and
// default timing parameters for the button debouncer.
package operand_input_pkg;

  // Datapath width shared with the ALU.
  localparam int DATA_W = 16;

  localparam int COUNT_W   = 8;
  localparam int DEB_CNT_W = 16;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_RELEASE = 2'd3
  } op_state_t;

endpackage

// File: rtl/operand_input_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; reusable for any
// asynchronous input that must be brought into the clk domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/operand_input.sv
// Operand entry: debounces the enter button, captures the switch value and
// emits a single request pulse per accepted press.
module operand_input
  import operand_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  sw,
  input  logic               btn,
  output logic [DATA_W-1:0]  in,
  output logic               rq,
  output logic               busy,
  output logic [COUNT_W-1:0] count
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_CNT_W-1:0] DEB_ONE  = DEB_CNT_W'(1);
  localparam logic [COUNT_W-1:0]   CNT_ONE  = COUNT_W'(1);

  logic                 btn_s;
  op_state_t            state_reg, state_next;
  logic [DEB_CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [DATA_W-1:0]    in_reg;
  logic                 rq_reg;
  logic                 busy_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 issue_next;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      deb_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      deb_cnt_reg <= deb_cnt_next;
    end
  end

  // The debounce counter only ever counts up to DEB_LAST before being cleared.
  always_comb begin
    state_next   = state_reg;
    deb_cnt_next = deb_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        deb_cnt_next = '0;
        if (btn_s) begin
          state_next = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (!btn_s) begin
          state_next   = ST_IDLE;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = ST_ISSUE;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_ONE;
        end
      end
      ST_ISSUE: begin
        state_next   = ST_RELEASE;
        deb_cnt_next = '0;
      end
      ST_RELEASE: begin
        if (btn_s) begin
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = ST_IDLE;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_ONE;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        deb_cnt_next = '0;
      end
    endcase
  end

  assign issue_next = (state_next == ST_ISSUE);

  // Outputs are registered from the next state so they line up with the state
  // register: rq and the freshly captured operand appear together in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg    <= '0;
      rq_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      rq_reg   <= issue_next;
      busy_reg <= (state_next != ST_IDLE);
      if (issue_next) begin
        in_reg    <= sw;
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  assign in    = in_reg;
  assign rq    = rq_reg;
  assign busy  = busy_reg;
  assign count = count_reg;

endmodule

// File: tb/tb_operand_input.sv
// Scoreboard bench for operand_input: stimulus pushes expected operands, a
// negedge monitor pops and compares whenever rq is presented.
module tb_operand_input;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] dut_in;
  logic        dut_rq;
  logic        dut_busy;
  logic [7:0]  dut_count;

  typedef struct {
    logic [15:0] v;
    logic [7:0]  c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] exp_in = 16'd0;
  int          exp_count = 0;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int last_rq_edge = -1;
  int rq_total = 0;

  operand_input #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .btn   (btn),
    .in    (dut_in),
    .rq    (dut_rq),
    .busy  (dut_busy),
    .count (dut_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Monitor: every rq cycle must match the oldest queued operand; otherwise
  // the captured operand must hold its last issued value.
  always @(negedge clk) begin
    if (dut_rq === 1'b1) begin
      rq_total++;
      last_rq_edge = edge_cnt;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rq: got rq=1 with in=%0d, expected no request (edge %0d)",
                 dut_in, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rq_in", int'(dut_in), int'(mon_e.v));
        chk("rq_count", int'(dut_count), int'(mon_e.c));
        $display("rq at edge %0d: in=%0d count=%0d", edge_cnt, dut_in, dut_count);
        exp_in = mon_e.v;
      end
    end else if (rst === 1'b0) begin
      chk("in_hold", int'(dut_in), int'(exp_in));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] v);
    exp_count = (exp_count + 1) % 256;
    exp_q.push_back('{v, 8'(exp_count)});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_in = 16'd0;
    exp_count = 0;
  endtask

  // Busy must still be high 5 edges after btn drops and low after the 6th:
  // two synchronizer edges plus four stable-low debounce cycles.
  task automatic check_release();
    repeat (5) step();
    chk("busy_release_hold", int'(dut_busy), 1);
    step();
    chk("busy_release_done", int'(dut_busy), 0);
    step();
  endtask

  // One full press. Edge numbering: the first edge sampling btn=1 is edge 1,
  // rq must be visible right after edge 7.
  task automatic do_press(input logic [15:0] v, input int hold, input bit bounce);
    int start;
    sw = v;
    push_exp(v);
    btn = 1'b1;
    start = edge_cnt;
    repeat (hold) step();
    chk("rq_latency", last_rq_edge, start + 7);
    btn = 1'b0;
    if (bounce) begin
      repeat (2) step();
      btn = 1'b1;
      step();
      btn = 1'b0;
    end
    check_release();
  endtask

  initial begin
    int start;
    rst = 1'b1;
    btn = 1'b0;
    sw  = 16'd0;
    repeat (3) step();
    chk("reset_in", int'(dut_in), 0);
    chk("reset_rq", int'(dut_rq), 0);
    chk("reset_busy", int'(dut_busy), 0);
    chk("reset_count", int'(dut_count), 0);
    rst = 1'b0;
    step();

    // Short bouncy pulses never reach the debounce threshold.
    sw = 16'd77;
    btn = 1'b1; step(); step();
    btn = 1'b0; step();
    btn = 1'b1; step(); step();
    btn = 1'b0;
    repeat (8) step();
    chk("bounce_press_busy", int'(dut_busy), 0);
    chk("bounce_press_count", int'(dut_count), 0);
    chk("bounce_press_in", int'(dut_in), 0);
    chk("bounce_press_rq_total", rq_total, 0);

    // Long hold gives exactly one request.
    do_press(16'd34, 20, 1'b0);
    chk("press1_count", int'(dut_count), 1);
    chk("press1_in", int'(dut_in), 34);
    chk("press1_rq_total", rq_total, 1);

    // Switch changes between presses must not reach in.
    sw = 16'd99;
    repeat (5) step();
    chk("sw_ignored_in", int'(dut_in), 34);
    do_press(16'd10, 10, 1'b0);
    chk("press2_in", int'(dut_in), 10);
    chk("press2_count", int'(dut_count), 2);

    // Bounce while releasing restarts the release debounce, no second rq.
    do_press(16'h1234, 10, 1'b1);
    chk("release_bounce_rq_total", rq_total, 3);
    chk("release_bounce_count", int'(dut_count), 3);

    // Reset during ISSUE, button held through reset release.
    sw = 16'h00AB;
    push_exp(16'h00AB);
    btn = 1'b1;
    for (int i = 0; i < 20 && dut_rq !== 1'b1; i++) step();
    chk("issue_reached", int'(dut_rq), 1);
    rst = 1'b1;
    step();
    chk("rst_issue_rq", int'(dut_rq), 0);
    chk("rst_issue_in", int'(dut_in), 0);
    chk("rst_issue_count", int'(dut_count), 0);
    chk("rst_issue_busy", int'(dut_busy), 0);
    rst = 1'b0;
    exp_in = 16'd0;
    exp_count = 0;
    sw = 16'h00CD;
    push_exp(16'h00CD);
    start = edge_cnt;
    repeat (10) step();
    chk("held_reset_latency", last_rq_edge, start + 7);
    chk("held_reset_count", int'(dut_count), 1);
    btn = 1'b0;
    check_release();

    // 256 presses wrap count back to zero; press 257 behaves normally.
    apply_reset();
    step();
    for (int i = 0; i < 256; i++) begin
      do_press(16'(i * 3 + 1), 8, 1'b0);
    end
    chk("wrap_count", int'(dut_count), 0);
    chk("wrap_in", int'(dut_in), 255 * 3 + 1);
    do_press(16'hBEEF, 8, 1'b0);
    chk("press257_count", int'(dut_count), 1);
    chk("press257_in", int'(dut_in), 16'hBEEF);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
